// File: rtl/ps2_key_receiver.sv
// ps2_key_receiver: PS/2 device-to-host frame receiver with E0/F0 prefix decoding.
module ps2_key_receiver #(
   parameter int FILTER_LEN     = 4,
   parameter int TIMEOUT_CYCLES = 5000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ps2_clk,
   input  logic        ps2_data,
   output logic [10:0] ps2_key,
   output logic        frame_err,
   output logic        busy
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [3:0] F_MAX = 4'(FILTER_LEN - 1);
   localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES - 1);
   logic          clk_s1, clk_s2, dat_s1, dat_s2, filt, fall_evt;
   logic [3:0]    fcnt, bit_cnt;
   logic [7:0]    shreg;
   logic          parity, ext_flag, rel_flag;
   logic [TW-1:0] to_cnt;
   assign busy = bit_cnt != 4'd0;
   always_ff @(posedge clk) begin
      if (!reset) begin
         {clk_s1, clk_s2, dat_s1, dat_s2, filt} <= 5'b11111;
         fcnt      <= '0;
         fall_evt  <= 1'b0;
         bit_cnt   <= '0;
         shreg     <= '0;
         parity    <= 1'b0;
         ext_flag  <= 1'b0;
         rel_flag  <= 1'b0;
         to_cnt    <= '0;
         ps2_key   <= '0;
         frame_err <= 1'b0;
      end else begin
         {clk_s1, clk_s2, dat_s1, dat_s2} <= {ps2_clk, clk_s1, ps2_data, dat_s1};
         frame_err <= 1'b0;
         fall_evt  <= filt && !clk_s2 && fcnt == F_MAX;
         // filtered clock only follows after FILTER_LEN consecutive differing samples
         if (clk_s2 == filt) fcnt <= '0;
         else if (fcnt == F_MAX) begin
            filt <= clk_s2;
            fcnt <= '0;
         end else fcnt <= fcnt + 4'd1;
         if (fall_evt) begin
            to_cnt <= '0;
            if (bit_cnt == 4'd0) bit_cnt <= dat_s2 ? 4'd0 : 4'd1;
            else if (bit_cnt <= 4'd8) begin
               shreg   <= {dat_s2, shreg[7:1]};
               bit_cnt <= bit_cnt + 4'd1;
            end else if (bit_cnt == 4'd9) begin
               parity  <= dat_s2;
               bit_cnt <= 4'd10;
            end else begin
               bit_cnt <= 4'd0;
               if (!(^{shreg, parity}) || !dat_s2) begin
                  frame_err <= 1'b1;
                  ext_flag  <= 1'b0;
                  rel_flag  <= 1'b0;
               end else if (shreg == 8'hE0) ext_flag <= 1'b1;
               else if (shreg == 8'hF0) rel_flag <= 1'b1;
               else begin
                  ps2_key  <= {~ps2_key[10], rel_flag, ext_flag, shreg};
                  ext_flag <= 1'b0;
                  rel_flag <= 1'b0;
               end
            end
         end else if (busy && to_cnt == T_MAX) begin
            bit_cnt   <= '0;
            ext_flag  <= 1'b0;
            rel_flag  <= 1'b0;
            frame_err <= 1'b1;
            to_cnt    <= '0;
         end else to_cnt <= busy ? to_cnt + 1'b1 : '0;
      end
   end
endmodule

// File: doc/ps2_key_receiver.md
Name: ps2_key_receiver

Overview:
Receives the PS/2 keyboard serial stream (device-to-host frames) on the raw ps2_clk/ps2_data pins. It decodes the E0 (extended) and F0 (break) prefixes and publishes each complete key event on the 11-bit ps2_key bus used by the keyboard matrix decoder. A new event is signalled by toggling ps2_key[10]. Sits between the board PS/2 pins and the Galaksija keyboard matrix block.

Parameters:
FILTER_LEN, 4, consecutive identical synchronized samples required before the filtered ps2_clk changes level (1..15).
TIMEOUT_CYCLES, 5000, clk cycles without a filtered falling edge, mid-frame, before the partial frame is abandoned.

Ports:
clk  in  1  system clock; all logic is on the rising edge.
reset  in  1  synchronous, active-low reset (0 = reset, sampled on clk rising edge).
ps2_clk  in  1  raw PS/2 clock pin, asynchronous, idle high.
ps2_data  in  1  raw PS/2 data pin, asynchronous, idle high.
ps2_key  out  11  [10] event toggle, [9] released (1 = break), [8] extended (E0-prefixed), [7:0] scan code.
frame_err  out  1  one-cycle pulse on parity error, stop error or timeout.
busy  out  1  high while a frame is partially received (bit_cnt != 0).

Behaviour:
- Reset (reset=0 at a clk edge):
  - ps2_key=0, frame_err=0, busy=0, bit_cnt=0, ext_flag=0, rel_flag=0, timeout counter=0.
  - Synchronizers and the filtered clock preset to 1, so no false edge occurs after reset.
  - Reset mid-frame discards the frame silently.
- Input conditioning:
  - 2-FF synchronizer on each pin.
  - Filtered clock takes the synchronized level after FILTER_LEN consecutive equal samples.
  - A fall_evt fires for one cycle on a 1->0 transition of the filtered clock.
  - Data is sampled from the synchronized ps2_data on the fall_evt cycle.
- Frame state machine: 11 bits, bit_cnt 0..10.
  - bit 0 (start): must be 0. If it is 1, ignore it and stay at bit_cnt=0 with no error.
  - bits 1-8: data, LSB first, shifted into an 8-bit register.
  - bit 9: parity. The total count of ones over data plus parity must be odd.
  - bit 10: stop, must be 1.
  - bit_cnt returns to 0 after bit 10 in all cases.
- On bit 10 with parity OK and stop=1 (byte b):
  - b==0xE0: ext_flag<=1. No event.
  - b==0xF0: rel_flag<=1. No event.
  - Any other byte: on the next clk edge after the stop-bit fall_evt, ps2_key[7:0]<=b, [8]<=ext_flag, [9]<=rel_flag, [10]<=~[10]. Then ext_flag<=0 and rel_flag<=0.
  - Output latency is exactly 1 clk after the stop-bit fall_evt.
  - All other bytes (0xAA, 0xFA, 0xE1, ...) are emitted unfiltered.
- On bit 10 with a parity error or stop=0:
  - No event; ps2_key unchanged.
  - ext_flag and rel_flag cleared.
  - frame_err pulses 1 cycle.
- Timeout:
  - The counter resets on every fall_evt and counts while bit_cnt != 0.
  - On reaching TIMEOUT_CYCLES: bit_cnt<=0, ext_flag and rel_flag cleared, frame_err pulses, counter cleared.
  - The counter holds at 0 when idle, so no timeout occurs between frames.
- ps2_key[9:0] holds its value between events.
- The toggle in bit [10] alternates with each event and wraps freely.
- The consumer detects an event as a change of [10]. Because [10] resets to 0, the consumer's shadow bit must also reset to 0.
- A glitch on ps2_clk shorter than FILTER_LEN cycles produces no fall_evt.

Test Plan:
- Make code 0x1C: frame bits 0,0,0,1,1,1,0,0,0,0(parity),1 -> 1 clk after the stop fall, ps2_key=11'b1_0_0_0001_1100 (toggle 1, rel 0, ext 0); frame_err stays 0.
- Break 0xF0 (parity 1), then 0x1C -> only one event: ps2_key[9]=1, [8]=0, [7:0]=0x1C, [10] toggled back to 0.
- Extended break E0, F0, 0x75 -> a single event with [9:8]=2'b11, [7:0]=0x75. The flags are clear afterwards: a following plain 0x29 gives [9:8]=00.
- 0x1C sent with parity bit 1 -> frame_err pulses once and ps2_key is unchanged. Then E0 followed by a parity-bad frame, then valid 0x75 -> ext=0 (prefix was discarded).
- Send 5 bits, then hold ps2_clk high for TIMEOUT_CYCLES -> frame_err pulses at count 5000 and busy falls. A subsequent full 0x29 frame decodes correctly.
- Pulse ps2_clk low for 2 clk cycles (FILTER_LEN=4) -> no bit is consumed and busy stays 0. Assert reset=0 mid-frame -> all outputs 0 and the next frame decodes normally.
